// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer: round-robin or fixed-priority grant feeding a
// registered output stage with valid/ready handshakes on both sides.
module rr_arb_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    ptr;
  logic                load_en;
  logic                found_lo, found_hi;
  logic [SEL_W-1:0]    lo_idx, hi_idx, win_idx;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    sel_data;

  assign load_en = !out_valid || out_ready;

  // Rotating search split in two passes: first valid at/above ptr, else lowest valid overall.
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (in_valid[i]) begin
        if (!found_lo) begin
          found_lo = 1'b1;
          lo_idx   = SEL_W'(i);
        end
        if (!found_hi && MODE == 0 && i >= 32'(ptr)) begin
          found_hi = 1'b1;
          hi_idx   = SEL_W'(i);
        end
      end
    end
    win_idx = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    grant    = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (found_lo && win_idx == SEL_W'(i)) begin
        grant[i] = 1'b1;
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (load_en && !rst) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (found_lo) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= win_idx;
        if (MODE == 0)
          ptr <= (win_idx == SEL_W'(CHANNELS-1)) ? '0 : win_idx + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a vector table on a 4-channel round-robin instance,
// plus hand sequences for reset, drain, 3-channel wrap-around and fixed priority.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-channel round-robin
  logic [3:0]   iv0 = '0;
  logic [127:0] id0;
  logic [3:0]   ir0;
  logic         ov0, or0 = 1'b1;
  logic [31:0]  od0;
  logic [1:0]   os0;
  // 3-channel round-robin
  logic [2:0]   iv3 = '0;
  logic [95:0]  id3;
  logic [2:0]   ir3;
  logic         ov3, or3 = 1'b1;
  logic [31:0]  od3;
  logic [1:0]   os3;
  // 4-channel fixed priority
  logic [3:0]   iv1 = '0;
  logic [127:0] id1;
  logic [3:0]   ir1;
  logic         ov1, or1 = 1'b1;
  logic [31:0]  od1;
  logic [1:0]   os1;

  rr_arb_mux u0 (.clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
                 .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(or0));
  rr_arb_mux #(.CHANNELS(3), .SEL_W(2)) u3 (.clk(clk), .rst(rst), .in_valid(iv3), .in_data(id3),
                 .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(or3));
  rr_arb_mux #(.MODE(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
                 .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(or1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_v;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[16];

  initial begin
    id0 = {32'h103, 32'h102, 32'h101, 32'h100};
    id3 = {32'h202, 32'h201, 32'h200};
    id1 = {32'h303, 32'h302, 32'h301, 32'h300};

    // valid, out_ready, in_ready, out_valid, out_sel, out_data after the edge
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h103};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101};
    tbl[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h101};
    tbl[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h101};
    tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102};
    tbl[9]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100};
    tbl[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h103};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'h103};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h103};
    tbl[13] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 32'h101};
    tbl[14] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h101};
    tbl[15] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100};

    #1;
    chk("rst in_ready", 32'(ir0), 32'h0);
    @(posedge clk); #1;
    chk("rst out_valid", 32'(ov0), 32'h0);
    chk("rst out_data", od0, 32'h0);
    chk("rst out_sel", 32'(os0), 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      iv0 = tbl[i].valid;
      or0 = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(ir0), 32'(tbl[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 32'(ov0), 32'(tbl[i].exp_v));
      chk($sformatf("vec%0d out_sel", i), 32'(os0), 32'(tbl[i].exp_sel));
      chk($sformatf("vec%0d out_data", i), od0, tbl[i].exp_data);
      @(negedge clk);
    end

    // Reset mid-transfer; ptr is 1 here so channel 1 is granted first
    id0[63:32] = 32'h0000DEAD;
    iv0 = 4'b0010; or0 = 1'b1;
    @(posedge clk); #1;
    chk("pre-rst out_data", od0, 32'hDEAD);
    @(negedge clk);
    iv0 = 4'b1111; or0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(ov0), 32'h0);
    chk("midrst out_data", od0, 32'h0);
    chk("midrst out_sel", 32'(os0), 32'h0);
    chk("midrst in_ready", 32'(ir0), 32'h0);
    or0 = 1'b1;
    #1;
    chk("midrst in_ready rdy", 32'(ir0), 32'h0);
    @(posedge clk); #1;
    chk("rst held out_valid", 32'(ov0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    id0[63:32] = 32'h101;
    iv0 = 4'b0110;
    #1;
    chk("post-rst in_ready", 32'(ir0), 32'h2);
    @(posedge clk); #1;
    chk("post-rst out_sel", 32'(os0), 32'h1);
    chk("post-rst out_valid", 32'(ov0), 32'h1);

    // Drain to empty: one valid cycle then empty, data held
    @(negedge clk);
    iv0 = 4'b0000;
    @(posedge clk); #1;
    chk("drain out_valid", 32'(ov0), 32'h0);
    chk("drain out_data", od0, 32'h101);
    @(posedge clk); #1;
    chk("drain stays empty", 32'(ov0), 32'h0);

    // Wrap-around on 3 channels
    @(negedge clk);
    iv3 = 3'b100;
    #1;
    chk("wrap grant2", 32'(ir3), 32'h4);
    @(posedge clk); #1;
    chk("wrap sel2", 32'(os3), 32'h2);
    chk("wrap data2", od3, 32'h202);
    @(negedge clk);
    iv3 = 3'b011;
    #1;
    chk("wrap grant0", 32'(ir3), 32'h1);
    @(posedge clk); #1;
    chk("wrap sel0", 32'(os3), 32'h0);
    @(negedge clk);
    iv3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap rr%0d sel", k), 32'(os3), 32'((k + 1) % 3));
      chk($sformatf("wrap rr%0d data", k), od3, 32'h200 + 32'((k + 1) % 3));
    end
    @(negedge clk);
    iv3 = 3'b000;

    // Fixed priority
    iv1 = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("prio%0d in_ready", k), 32'(ir1), 32'h2);
      @(posedge clk); #1;
      chk($sformatf("prio%0d sel", k), 32'(os1), 32'h1);
      chk($sformatf("prio%0d data", k), od1, 32'h301);
      @(negedge clk);
    end
    iv1 = 4'b1100;
    #1;
    chk("prio ch2 in_ready", 32'(ir1), 32'h4);
    @(posedge clk); #1;
    chk("prio ch2 sel", 32'(os1), 32'h2);
    @(negedge clk);
    iv1 = 4'b1111; or1 = 1'b0;
    #1;
    chk("prio stall in_ready", 32'(ir1), 32'h0);
    @(posedge clk); #1;
    chk("prio stall sel", 32'(os1), 32'h2);
    @(negedge clk);
    iv1 = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N-channel arbitrated multiplexer with per-channel valid/ready handshakes and a registered output stage. Each cycle it selects at most one requesting input channel, by round-robin or fixed priority, and loads that channel's data into an output register. The block is the sequential successor of the combinational MuxNT1 family. It is used wherever several pipeline producers share one consumer, e.g. I/D-side requests contending for a single bus port.

Parameters:
WIDTH, 32, data width per channel
CHANNELS, 4, number of input channels (2..16; non-power-of-two allowed)
SEL_W, 2, width of channel index; must be >= clog2(CHANNELS)
MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  CHANNELS  per-channel request valid
in_data  input  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  CHANNELS  per-channel accept; at most one bit high
out_valid  output  1  output register holds valid data
out_data  output  WIDTH  registered selected data
out_sel  output  SEL_W  index of the channel that supplied out_data
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_sel=0, rr pointer=0. Takes effect immediately, including mid-transfer. The in_ready bits are all 0 while rst=1. Pending words in the output register are discarded.
- load_en = !out_valid | out_ready. The register is empty or is being drained this cycle.
- Grant (combinational): in MODE 0, search in_valid starting at ptr, then ptr+1, wrapping CHANNELS-1 -> 0. The first valid channel wins. In MODE 1, the lowest-index valid channel wins and ptr is ignored.
- in_ready[i] = load_en & grant[i]. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer: out_data <= in_data[i], out_sel <= i, out_valid <= 1. In MODE 0, ptr <= (i==CHANNELS-1) ? 0 : i+1.
- If load_en and no in_valid: out_valid <= 0 and ptr is unchanged. out_data and out_sel hold their last values.
- If !load_en (out_valid & !out_ready): out_data, out_sel and out_valid hold stable, all in_ready=0, and ptr holds.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous drain and load in the same cycle is required (no bubble).
- in_ready depends combinationally on out_ready and in_valid. There is no combinational path from in_data to any output.
- Producers may raise or drop in_valid freely. A non-granted channel is not consumed and keeps waiting.
- Fairness (MODE 0): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,CHANNELS-1,0,...
- Starvation bound (MODE 0): a continuously valid channel is granted within CHANNELS accepted transfers.
- Unused index range: ptr never takes a value >= CHANNELS. out_sel upper bits beyond clog2(CHANNELS) are 0.
- ptr is a SEL_W-bit register.

Test Plan:
- Reset mid-transfer: out_valid=1, out_data=0xDEAD, rst pulsed between edges -> out_valid, out_data and out_sel read 0 immediately, and all in_ready=0 during reset. After release, the first grant goes to the lowest valid channel at or above index 0.
- Round-robin fairness: CHANNELS=4, MODE 0, all in_valid=1, in_data[i]=0x100+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles and out_data 0x100..0x103 repeating, with no idle cycles.
- Backpressure: out_valid=1 with out_data=0x55, out_ready=0 for 3 cycles, channel 2 valid -> out_data stays 0x55, in_ready=0000, ptr unchanged. When out_ready=1, channel 2 is accepted in the same cycle and out_data=in_data[2] on the next edge.
- Wrap-around: CHANNELS=3 (SEL_W=2), only channel 2 valid, then only channel 0 -> grant 2, then ptr=0 and grant 0. out_sel is never 3.
- Fixed priority: MODE 1, in_valid=0110 held for 4 transfers -> out_sel=1 every time and channel 2 is never granted.
- Drain to empty: a single transfer from channel 1, then in_valid=0 and out_ready=1 -> out_valid=1 for exactly one cycle, then 0. out_data holds its last value.
